// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the future transmitter).
// Contents:
//   parity_e      - parity_type encodings
//   rx_state_e    - receiver FSM states
//   ERR_*         - bit positions within error_flag
//   majority3()   - 2-of-3 vote used for mid-bit sampling
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone  = 2'b00,
    ParOdd   = 2'b01,
    ParEven  = 2'b10,
    ParNone3 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

  localparam int unsigned ERR_PAR = 0;
  localparam int unsigned ERR_FRM = 1;
  localparam int unsigned ERR_OVR = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div_i and pulses tick_o for one clock
// while the count equals div_i, giving a tick every div_i+1 clocks.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear, realigns the tick phase
//   div_i  - tick period minus one, in clocks
//   tick_o - one-clock tick pulse
module uart_baud_tick #(
  parameter int unsigned DivW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DivW'(1);
    // >= rather than == so a divisor shrinking under the count still wraps
    if (clr_i || (cnt_q >= div_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == div_i);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote mid-bit sampling, optional
// parity, 1/2 stop bits, break detection and a valid/ready output.
// Ports:
//   clk, reset (async, active low)
//   data_rx     - serial line, idle high, asynchronous
//   baud_div    - tick period minus one; bit period is OVS ticks
//   parity_type - 00/11 none, 01 odd, 10 even
//   two_stop    - expect two stop bits
//   rx_data, rx_valid, rx_ready - received word with valid/ready handshake
//   active_flag - a frame is in progress
//   error_flag  - [0] parity, [1] framing, [2] overrun; qualified by rx_valid
//   break_flag  - one-cycle pulse alongside rx_valid rising for a break frame
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_rx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_type,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              active_flag,
  output logic [2:0]        error_flag,
  output logic              break_flag
);

  localparam int unsigned TickW = $clog2(OVS);
  localparam int unsigned CntW  = $clog2(DATA_W);
  localparam logic [TickW-1:0] SampA    = TickW'(OVS / 2 - 1);
  localparam logic [TickW-1:0] SampB    = TickW'(OVS / 2);
  localparam logic [TickW-1:0] SampC    = TickW'(OVS / 2 + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVS - 1);
  localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_W - 1);

  rx_state_e state_q, state_d;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_W-1:0] div_q, tick_div;
  parity_e par_q;
  logic two_stop_q;
  logic tick, start_det, decide, bit_val, par_en, line_break, frame_done;
  logic [TickW-1:0] tick_idx_q;
  logic samp_a_q, samp_b_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [DATA_W-1:0] shift_q, rx_data_q;
  logic par_err_q, frm_err_q, zeros_q, brk_wait_q;
  logic rx_valid_q, break_q, handshake;
  logic [2:0] err_q, err_new;

  // Line synchroniser; resets to idle-high so reset release is not a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= data_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // After a break the line must go high again before a new start is armed.
  assign start_det = (state_q == StIdle) && !brk_wait_q && rx_prev_q && !rx_sync_q;
  assign tick_div  = (state_q == StIdle) ? baud_div : div_q;

  uart_baud_tick #(
    .DivW (DIV_W)
  ) u_baud_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (start_det),
    .div_i  (tick_div),
    .tick_o (tick)
  );

  // Bit decisions happen on the third vote sample; state changes there too, so
  // the tick index keeps running across bit boundaries.
  assign decide     = tick && (state_q != StIdle) && (tick_idx_q == SampC);
  assign bit_val    = majority3(samp_a_q, samp_b_q, rx_sync_q);
  assign par_en     = (par_q == ParOdd) || (par_q == ParEven);
  assign line_break = (state_q == StStop1) && !bit_val && zeros_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_det) state_d = StStart;
      StStart:  if (decide) state_d = bit_val ? StIdle : StData;
      StData:   if (decide && (bit_cnt_q == LastBit)) state_d = par_en ? StParity : StStop1;
      StParity: if (decide) state_d = StStop1;
      StStop1:  if (decide) state_d = (two_stop_q && !line_break) ? StStop2 : StIdle;
      StStop2:  if (decide) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    active_flag = (state_q != StIdle);
    frame_done  = decide && (((state_q == StStop1) && (!two_stop_q || line_break)) ||
                             (state_q == StStop2));
    err_new          = '0;
    err_new[ERR_PAR] = par_err_q;
    err_new[ERR_FRM] = frm_err_q | ~bit_val;
  end

  // Receive datapath: tick phase, vote samples, shift register, error tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_idx_q <= '0;
      samp_a_q   <= 1'b0;
      samp_b_q   <= 1'b0;
      div_q      <= '0;
      par_q      <= ParNone;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      zeros_q    <= 1'b0;
      brk_wait_q <= 1'b0;
    end else begin
      if (start_det) begin
        tick_idx_q <= '0;
      end else if (tick && (state_q != StIdle)) begin
        tick_idx_q <= (tick_idx_q == TickLast) ? '0 : tick_idx_q + TickW'(1);
      end
      if (tick && (tick_idx_q == SampA)) samp_a_q <= rx_sync_q;
      if (tick && (tick_idx_q == SampB)) samp_b_q <= rx_sync_q;

      if (start_det) begin
        div_q      <= baud_div;
        par_q      <= parity_e'(parity_type);
        two_stop_q <= two_stop;
        bit_cnt_q  <= '0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
        zeros_q    <= 1'b1;
      end else if (decide) begin
        case (state_q)
          StData: begin
            shift_q   <= {bit_val, shift_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            if (bit_val) zeros_q <= 1'b0;
          end
          StParity: begin
            // Odd parity wants an odd count of ones across data and parity bit.
            par_err_q <= (^{shift_q, bit_val}) != (par_q == ParOdd);
            if (bit_val) zeros_q <= 1'b0;
          end
          StStop1: if (!bit_val) frm_err_q <= 1'b1;
          default: ;
        endcase
      end

      if (frame_done && line_break) begin
        brk_wait_q <= 1'b1;
      end else if ((state_q == StIdle) && rx_sync_q) begin
        brk_wait_q <= 1'b0;
      end
    end
  end

  assign handshake = rx_valid_q && rx_ready;

  // Output holding register; a frame finishing while the held word is not
  // being taken is dropped and flagged as overrun on the held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
      break_q    <= 1'b0;
    end else if (frame_done && (!rx_valid_q || handshake)) begin
      rx_data_q  <= shift_q;
      rx_valid_q <= 1'b1;
      err_q      <= err_new;
      break_q    <= line_break;
    end else begin
      break_q <= 1'b0;
      if (frame_done) begin
        err_q[ERR_OVR] <= 1'b1;
      end else if (handshake) begin
        rx_valid_q <= 1'b0;
        err_q      <= '0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign error_flag = err_q;
  assign break_flag = break_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
module tb_uart_rx_ovs;

  logic        clk;
  logic        reset;
  logic        data_rx;
  logic [15:0] baud_div;
  logic [1:0]  parity_type;
  logic        two_stop;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        active_flag;
  logic [2:0]  error_flag;
  logic        break_flag;

  int total    = 0;
  int bad      = 0;
  int bit_clk  = 64;
  int cyc      = 0;
  int rise_cyc = 0;
  int brk_cnt  = 0;
  int brk_base = 0;
  logic valid_d = 1'b0;

  uart_rx_ovs #(
    .DATA_W (8),
    .OVS    (16),
    .DIV_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_rx     (data_rx),
    .baud_div    (baud_div),
    .parity_type (parity_type),
    .two_stop    (two_stop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .active_flag (active_flag),
    .error_flag  (error_flag),
    .break_flag  (break_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observers: rx_valid rise time and number of cycles break_flag is high.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    valid_d <= rx_valid;
    if (rx_valid && !valid_d) rise_cyc <= cyc;
    if (break_flag) brk_cnt <= brk_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold one bit on the line; gl inverts it for a single clock mid-bit.
  task automatic drive_bit(input logic b, input logic gl);
    for (int i = 0; i < bit_clk; i++) begin
      data_rx = (gl && i == 34) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                            input logic two, input logic s2, input int gl_bit);
    parity_type = pt;
    two_stop    = two;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], gl_bit == i);
    if (pt == 2'b01 || pt == 2'b10) drive_bit(pbit, 1'b0);
    drive_bit(1'b1, 1'b0);
    if (two) drive_bit(s2, 1'b0);
    data_rx = 1'b1;
  endtask

  // Parity bit that makes the frame correct.
  function automatic logic good_par(input logic [7:0] d, input logic [1:0] pt);
    int ones = $countones(d);
    return (pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Expected error_flag for a delivered (non-overrun) frame with stop1 = 1.
  function automatic logic [2:0] model_err(input logic [7:0] d, input logic [1:0] pt,
                                           input logic pbit, input logic two, input logic s2);
    int  ones = $countones(d) + int'(pbit);
    logic even_total = (ones % 2 == 0);
    logic par_bad = (pt == 2'b10 && !even_total) || (pt == 2'b01 && even_total);
    return {1'b0, two && !s2, par_bad};
  endfunction

  task automatic expect_frame(input string tag, input logic [7:0] ed, input logic [2:0] ee,
                              input int ebrk);
    int n = 0;
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(ed));
    chk({tag, "_err"}, 32'(error_flag), 32'(ee));
    chk({tag, "_brk"}, 32'(brk_cnt - brk_base), 32'(ebrk));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rx_valid), 32'd0);
    brk_base = brk_cnt;
  endtask

  initial begin
    int t0;
    int lat;
    logic [7:0] d;
    logic [1:0] pt;
    logic two, s2, pbit;

    reset       = 1'b0;
    data_rx     = 1'b1;
    baud_div    = 16'd3;
    parity_type = 2'b10;
    two_stop    = 1'b0;
    rx_ready    = 1'b0;
    bit_clk     = 64;
    idle(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_err", 32'(error_flag), 32'd0);
    chk("rst_active", 32'(active_flag), 32'd0);
    chk("rst_brk", 32'(break_flag), 32'd0);
    reset = 1'b1;
    idle(20);
    brk_base = brk_cnt;

    // Even parity, good frame, with latency window check
    t0 = cyc;
    send_frame(8'hA5, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    lat = rise_cyc - t0;
    chk("a5_latency", 32'(lat >= 640 && lat < 704), 32'd1);
    expect_frame("a5_even", 8'hA5, 3'b000, 0);
    idle(16);

    send_frame(8'hA5, 2'b10, 1'b1, 1'b0, 1'b1, -1);
    expect_frame("a5_parerr", 8'hA5, 3'b001, 0);
    idle(16);

    send_frame(8'h00, 2'b01, 1'b1, 1'b0, 1'b1, -1);
    expect_frame("odd_00", 8'h00, 3'b000, 0);
    idle(16);

    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, -1);
    expect_frame("stop2_bad", 8'h3C, 3'b010, 0);
    idle(16);

    // Break: line low for more than a frame, then must not restart while low
    parity_type = 2'b10;
    two_stop    = 1'b0;
    data_rx     = 1'b0;
    idle(13 * bit_clk);
    expect_frame("break", 8'h00, 3'b010, 1);
    idle(2 * bit_clk);
    chk("break_noact", 32'(active_flag), 32'd0);
    chk("break_noval", 32'(rx_valid), 32'd0);
    data_rx = 1'b1;
    idle(bit_clk);
    send_frame(8'h96, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    expect_frame("after_brk", 8'h96, 3'b000, 0);
    idle(16);

    // False start from a short low glitch
    data_rx = 1'b0;
    idle(10);
    chk("glitch_act", 32'(active_flag), 32'd1);
    idle(10);
    data_rx = 1'b1;
    idle(3 * bit_clk);
    chk("glitch_idle", 32'(active_flag), 32'd0);
    chk("glitch_noval", 32'(rx_valid), 32'd0);

    // Single-clock high spike inside data bit 3 is outvoted
    send_frame(8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 3);
    expect_frame("spike", 8'h00, 3'b000, 0);
    idle(16);

    // Overrun: second frame dropped, flag on held word
    send_frame(8'h11, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    send_frame(8'h22, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_err", 32'(error_flag), 32'b100);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("ovr_drop", 32'(rx_valid), 32'd0);
    idle(16);
    send_frame(8'h33, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    expect_frame("after_ovr", 8'h33, 3'b000, 0);
    idle(16);

    // Reset mid-frame with a word still held
    send_frame(8'h7E, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    reset = 1'b0;
    idle(2);
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    chk("mrst_data", 32'(rx_data), 32'd0);
    chk("mrst_err", 32'(error_flag), 32'd0);
    chk("mrst_active", 32'(active_flag), 32'd0);
    chk("mrst_brk", 32'(break_flag), 32'd0);
    data_rx = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(bit_clk);
    send_frame(8'hC3, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    expect_frame("c3", 8'hC3, 3'b000, 0);
    idle(2 * bit_clk);
    chk("c3_only", 32'(rx_valid), 32'd0);

    // Random frames against the model
    for (int k = 0; k < 12; k++) begin
      baud_div = 16'($urandom_range(1, 3));
      bit_clk  = (int'(baud_div) + 1) * 16;
      d        = 8'($urandom);
      pt       = 2'($urandom_range(0, 3));
      two      = 1'($urandom_range(0, 1));
      s2       = ($urandom_range(0, 3) != 0);
      pbit     = good_par(d, pt) ^ ($urandom_range(0, 3) == 0);
      idle(bit_clk);
      send_frame(d, pt, pbit, two, s2, -1);
      expect_frame($sformatf("rnd%0d", k), d, model_err(d, pt, pbit, two, s2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
